// File: rtl/mem_io_unit.sv
// Memory and I/O slave on the core's external bus: word-addressed RAM plus a
// memory-mapped serial transmitter (TXDATA push port, STATUS register) backed
// by a small FIFO. All bus accesses complete in the cycle they are presented.
module mem_io_unit #(
  parameter int ADDR_W     = 8,
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] address_bus,
  inout  wire  [15:0] data_bus,
  output logic        tx,
  output logic        tx_busy,
  output logic        ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [15:0]      TXDATA_A = 16'hFFF0;
  localparam logic [15:0]      STATUS_A = 16'hFFF1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             wr_q;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [15:0]      ram [2**ADDR_W];
  logic [15:0]      rdata;

  logic ram_hit, strobe, push, push_ok, pop, clr, full, empty, bit_end;

  // Only the first cycle of a low wr strobe triggers register side effects,
  // so a core holding wr low for several cycles pushes exactly once.
  assign ram_hit = ((address_bus >> ADDR_W) == 16'd0);
  assign strobe  = wr_q & ~wr;
  assign push    = strobe & (address_bus == TXDATA_A);
  assign clr     = strobe & (address_bus == STATUS_A) & data_bus[3];
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign pop     = (state_q == S_IDLE) & ~empty;
  assign push_ok = push & (~full | pop);
  assign bit_end = (baud_q == BAUD_MAX);

  assign tx_busy = (state_q != S_IDLE) | ~empty;
  assign ovf     = ovf_q;

  // FIFO pointer/count bookkeeping and sticky overflow (set beats clear).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (clr)               ovf_d = 1'b0;
    if (push && !push_ok)  ovf_d = 1'b1;
  end

  // Transmitter next state and line level; IDLE pops the FIFO head directly.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d = fifo_mem[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx     = 1'b0;
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with asynchronous active-low reset; a reset mid-frame
  // returns the FSM to IDLE at once, which forces tx high and drops the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      wr_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      wr_q    <= wr;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Datapath storage: shift register, FIFO entries and RAM are never reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push_ok) fifo_mem[wptr_q] <= data_bus[7:0];
    if (!wr && ram_hit) ram[address_bus[ADDR_W-1:0]] <= data_bus;
  end

  // Combinational read mux; unmapped addresses and TXDATA read as zero.
  always_comb begin
    rdata = '0;
    if (ram_hit)                      rdata = ram[address_bus[ADDR_W-1:0]];
    else if (address_bus == STATUS_A) rdata = {12'b0, ovf_q, tx_busy, full, empty};
  end

  assign data_bus = wr ? rdata : {16{1'bz}};

endmodule

// File: tb/tb_mem_io_unit.sv
// Bench for mem_io_unit: a queue-based reference model of the FIFO and the
// frame timing, a read scoreboard and a serial frame decoder.
module tb_mem_io_unit;
  localparam int ADDR_W     = 8;
  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;
  localparam logic [15:0] UNM = 16'h0200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b1;
  logic [15:0] addr = UNM;
  logic [15:0] drv = 16'h0000;
  wire  [15:0] data_bus;
  logic        tx, tx_busy, ovf;

  assign data_bus = wr ? 16'hzzzz : drv;
  always #5 clk = ~clk;

  mem_io_unit #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .address_bus(addr), .data_bus(data_bus),
    .tx(tx), .tx_busy(tx_busy), .ovf(ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_q[$];
  logic [7:0]  exp_frame_q[$];
  logic [15:0] m_ram [256];
  int          m_rem = 0;
  logic [7:0]  m_cur = 8'h00;
  logic        m_ovf = 1'b0;
  logic        m_wrp = 1'b1;
  logic        mp_pop, mp_push, mp_clr, mp_full;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      exp_frame_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      m_wrp = 1'b1;
    end else begin
      mp_full = (m_q.size() == FIFO_DEPTH);
      mp_pop  = (m_rem == 0) && (m_q.size() != 0);
      mp_push = m_wrp && !wr && (addr == 16'hFFF0);
      mp_clr  = m_wrp && !wr && (addr == 16'hFFF1) && drv[3];
      if (mp_pop) begin
        m_cur = m_q.pop_front();
        exp_frame_q.push_back(m_cur);
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (mp_clr) m_ovf = 1'b0;
      if (mp_push) begin
        if (mp_full && !mp_pop) m_ovf = 1'b1;
        else                    m_q.push_back(drv[7:0]);
      end
      if (!wr && ((addr >> ADDR_W) == 16'd0)) m_ram[addr[ADDR_W-1:0]] = drv;
      m_wrp = wr;
    end
  end

  function automatic logic m_busy();
    return (m_rem != 0) || (m_q.size() != 0);
  endfunction

  function automatic logic [15:0] m_status();
    return {12'b0, m_ovf, m_busy(), m_q.size() == FIFO_DEPTH, m_q.size() == 0};
  endfunction

  // Expected line level from elapsed time inside the current frame.
  function automatic logic m_txexp();
    int el, idx;
    if (m_rem == 0) return 1'b1;
    el  = FRAME - m_rem;
    idx = el / CLK_DIV;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if ((a >> ADDR_W) == 16'd0) return m_ram[a[ADDR_W-1:0]];
    if (a == 16'hFFF1)          return m_status();
    return 16'h0000;
  endfunction

  // ---------------- monitor ----------------
  logic [15:0] rd_exp[$];
  logic [15:0] rd_adr[$];
  logic        dec_act = 1'b0;
  int          dec_cnt = 0;
  int          dec_idx = 0;
  logic [7:0]  dec_byte = 8'h00;
  logic [15:0] exp_b;

  always @(negedge clk) begin
    chk("tx_line", {15'b0, tx}, {15'b0, m_txexp()});
    chk("tx_busy", {15'b0, tx_busy}, {15'b0, m_busy()});
    chk("ovf", {15'b0, ovf}, {15'b0, m_ovf});
    if (!wr) chk("bus_released", data_bus, drv);
    if (wr && rd_exp.size() > 0) begin
      exp_b = rd_exp.pop_front();
      chk((rd_adr.pop_front() == 16'hFFF1) ? "rd_status" : "rd_data", data_bus, exp_b);
    end
    if (!reset) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (!tx) begin
        dec_act = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CLK_DIV == CLK_DIV / 2) begin
        dec_idx = dec_cnt / CLK_DIV;
        if (dec_idx == 0) begin
          chk("start_bit", {15'b0, tx}, 16'h0000);
        end else if (dec_idx <= 8) begin
          dec_byte[dec_idx-1] = tx;
        end else begin
          chk("stop_bit", {15'b0, tx}, 16'h0001);
          chk("frame_expected", {15'b0, exp_frame_q.size() != 0}, 16'h0001);
          if (exp_frame_q.size() != 0) chk("frame_byte", {8'h00, dec_byte}, {8'h00, exp_frame_q.pop_front()});
          dec_act = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      wr = 1'b1;
      addr = UNM;
    end
  endtask

  task automatic wr_bus(input logic [15:0] a, input logic [15:0] d, input int hold = 1);
    cyc();
    wr = 1'b0;
    addr = a;
    drv = d;
    repeat (hold - 1) cyc();
    cyc();
    wr = 1'b1;
    addr = UNM;
  endtask

  task automatic rd_bus(input logic [15:0] a, input int e = -1);
    cyc();
    wr = 1'b1;
    addr = a;
    rd_adr.push_back(a);
    rd_exp.push_back((e >= 0) ? 16'(e) : m_read(a));
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy() || dec_act) && n < 4000) begin
      cyc();
      n++;
    end
    idle(2);
    chk("frames_pending", 16'(exp_frame_q.size()), 16'h0000);
  endtask

  logic [15:0] written[$];
  logic [15:0] ra;

  initial begin
    #1000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held, then released between edges
    idle(3);
    @(negedge clk);
    #2 reset = 1'b1;
    rd_bus(16'hFFF1, 16'h0001);

    // RAM and address decode
    wr_bus(16'h0000, 16'h1111);
    wr_bus(16'h0005, 16'h1234);
    rd_bus(16'h0005, 16'h1234);
    wr_bus(16'h0100, 16'hBEEF);
    rd_bus(16'h0100, 16'h0000);
    rd_bus(16'h0000, 16'h1111);
    rd_bus(16'hFFF0, 16'h0000);
    rd_bus(16'hFFF2, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 255));
      wr_bus(ra, 16'($urandom));
      written.push_back(ra);
    end
    foreach (written[i]) rd_bus(written[i]);

    // single frame 0xA5
    wr_bus(16'hFFF0, 16'h00A5);
    drain();

    // held strobe pushes once
    wr_bus(16'hFFF0, 16'h0041, 5);
    rd_bus(16'hFFF1, 16'h0005);
    drain();

    // six back-to-back bytes: one in flight, four queued, one dropped
    for (int i = 0; i < 6; i++) wr_bus(16'hFFF0, 16'($urandom_range(0, 255)));
    rd_bus(16'hFFF1, 16'h000E);
    wr_bus(16'hFFF1, 16'h0008);
    rd_bus(16'hFFF1, 16'h0006);
    wr_bus(16'hFFF0, 16'h00C3);
    rd_bus(16'hFFF1, 16'h000E);
    wr_bus(16'hFFF1, 16'h0007);
    rd_bus(16'hFFF1, 16'h000E);
    wr_bus(16'hFFF1, 16'h0008);
    drain();

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: wr_bus(16'hFFF0, 16'($urandom), $urandom_range(1, 3));
        1: rd_bus(16'hFFF1);
        2: begin
          ra = 16'($urandom_range(0, 255));
          wr_bus(ra, 16'($urandom));
          written.push_back(ra);
        end
        3: rd_bus(written[$urandom_range(0, written.size() - 1)]);
        4: idle($urandom_range(1, 200));
        default: wr_bus(16'hFFF1, 16'($urandom));
      endcase
    end
    drain();

    // reset in the middle of the data bits
    wr_bus(16'hFFF0, 16'h005A);
    wr_bus(16'hFFF0, 16'h0033);
    idle(2 + 3 * CLK_DIV + 5);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("reset_tx", {15'b0, tx}, 16'h0001);
    chk("reset_busy", {15'b0, tx_busy}, 16'h0000);
    @(negedge clk);
    #2 reset = 1'b1;
    rd_bus(16'hFFF1, 16'h0001);
    idle(2 * FRAME);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
